// File: rtl/dr_sync_sink.sv
// Clocked sink for a dual-rail delay-insensitive link: synchronises the rails,
// detects token completion (two-phase or four-phase), decodes to a valid/ready register.
module dr_sync_sink #(
    parameter string ENC         = "TP",
    parameter int    WIDTH       = 32,
    parameter int    SYNC_STAGES = 2,
    parameter int    RAIL_NUM    = 2
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic [WIDTH-1:0][RAIL_NUM-1:0]   in,
    output logic                             ack_o,
    output logic [WIDTH-1:0]                 data_o,
    output logic                             valid_o,
    input  logic                             ready_i,
    output logic                             err_o
);

    localparam bit IS_FP = (ENC == "FP");

    localparam logic [0:0] WAIT_DATA   = 1'b0;
    localparam logic [0:0] WAIT_SPACER = 1'b1;

    if (RAIL_NUM != 2) begin : g_bad_rail_num
        $error("dr_sync_sink: RAIL_NUM must be 2");
    end
    if (SYNC_STAGES < 2) begin : g_bad_sync_stages
        $error("dr_sync_sink: SYNC_STAGES must be at least 2");
    end
    if (ENC != "TP" && ENC != "FP") begin : g_bad_enc
        $error("dr_sync_sink: ENC must be \"TP\" or \"FP\"");
    end

    logic [WIDTH-1:0][RAIL_NUM-1:0] sync_q [SYNC_STAGES];
    logic [WIDTH-1:0][RAIL_NUM-1:0] syn;
    logic [WIDTH-1:0][RAIL_NUM-1:0] syn_d;
    logic [WIDTH-1:0][RAIL_NUM-1:0] prev;
    logic [0:0]                     state;

    logic [RAIL_NUM-1:0] cmp;
    logic [WIDTH-1:0]    decoded;
    logic                complete;
    logic                conflict;
    logic                stable_sample;
    logic                stable;
    logic                spacer_seen;
    logic                capture;
    logic                err_set;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < SYNC_STAGES; i++) begin
                sync_q[i] <= '0;
            end
            syn_d <= '0;
        end else begin
            sync_q[0] <= in;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                sync_q[i] <= sync_q[i-1];
            end
            syn_d <= syn;
        end
    end

    assign syn = sync_q[SYNC_STAGES-1];

    // TP compares against the last captured rails (a toggle marks the bit); FP looks at levels.
    always_comb begin
        cmp      = '0;
        decoded  = '0;
        complete = 1'b1;
        conflict = 1'b0;
        for (int i = 0; i < WIDTH; i++) begin
            cmp        = IS_FP ? syn[i] : (syn[i] ^ prev[i]);
            decoded[i] = cmp[1];
            case (cmp)
                2'b01, 2'b10: ;
                2'b11: begin
                    conflict = 1'b1;
                    complete = 1'b0;
                end
                default: complete = 1'b0;
            endcase
        end
    end

    assign stable_sample = (syn == syn_d);
    assign stable        = stable_sample && complete;
    assign spacer_seen   = (syn == '0) && (syn_d == '0);
    assign capture       = (state == WAIT_DATA) && stable && (!valid_o || ready_i);
    assign err_set       = (state == WAIT_DATA) && stable_sample && conflict;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ack_o   <= 1'b0;
            data_o  <= '0;
            valid_o <= 1'b0;
            err_o   <= 1'b0;
            prev    <= '0;
            state   <= WAIT_DATA;
        end else begin
            if (err_set) begin
                err_o <= 1'b1;
            end

            if (capture) begin
                data_o  <= decoded;
                valid_o <= 1'b1;
                if (IS_FP) begin
                    ack_o <= 1'b1;
                    state <= WAIT_SPACER;
                end else begin
                    prev  <= syn;
                    ack_o <= ~ack_o;
                end
            end else if (valid_o && ready_i) begin
                valid_o <= 1'b0;
            end

            if (state == WAIT_SPACER && spacer_seen) begin
                ack_o <= 1'b0;
                state <= WAIT_DATA;
            end
        end
    end

endmodule

// File: doc/dr_sync_sink.md
Name: dr_sync_sink

Overview:
- Clocked consumer of a dual-rail delay-insensitive link, e.g. {c_out, s} of int_adder with WIDTH=33.
- Synchronises the rails into the clk domain and detects token completion.
- Decodes each token to binary and presents it on a valid/ready interface.
- Returns the link acknowledge to the upstream asynchronous stage.

Parameters:
- ENC, "TP": link protocol. "TP" is two-phase transition signalling; "FP" is four-phase return-to-zero.
- WIDTH, 32: number of dual-rail bits.
- SYNC_STAGES, 2: flip-flop synchroniser depth per rail, minimum 2.
- RAIL_NUM, 2: rails per bit. Fixed at 2; any other value is an elaboration error.

Ports:
- clk  input  1  system clock.
- rst  input  1  reset, asynchronous, active-high.
- in  input  [WIDTH-1:0][RAIL_NUM-1:0]  dual-rail data. Rail[1] = logic 1, rail[0] = logic 0.
- ack_o  output  1  link acknowledge to the upstream stage; driven from a flop.
- data_o  output  WIDTH  decoded binary token.
- valid_o  output  1  data_o holds an unconsumed token.
- ready_i  input  1  consumer accepts data_o when valid_o && ready_i at a clk edge.
- err_o  output  1  sticky protocol-violation flag.

Behaviour:
- Reset (asynchronous, active-high): ack_o=0, valid_o=0, data_o=0, err_o=0, previous-rail register prev=0, synchronisers=0, FSM=WAIT_DATA. Reset asserted mid-token aborts the token with no ack. After reset, upstream is assumed to be reset as well (rails at 0).
- Synchronisation:
  - Every rail passes through SYNC_STAGES flops, giving syn.
  - A token is "stable" when syn is complete and equal to its value one cycle earlier.
- Completion, TP: each bit has exactly one rail where syn differs from prev. Bit value = 1 if rail[1] toggled.
- Completion, FP: each bit has exactly one rail high. Bit value = syn rail[1]. Spacer = all rails 0.
- Errors: in a stable sample, a bit with both rails toggled (TP) or both rails high (FP) sets err_o. err_o clears only on rst. The token is still handled as incomplete (no capture).
- Buffering: one-entry output register.
  - Capture is allowed when the token is stable and (valid_o==0 or ready_i==1) in the same cycle.
  - Simultaneous accept and capture: data_o is replaced, valid_o stays 1, with no bubble.
- FSM:
  - WAIT_DATA: on capture, data_o<=decoded value and valid_o<=1.
    - TP: prev<=syn, ack_o toggles, stay in WAIT_DATA.
    - FP: ack_o<=1, go to WAIT_SPACER.
  - WAIT_SPACER (FP only): when syn is all-zero for 2 consecutive cycles, ack_o<=0 and go to WAIT_DATA. Any non-zero rail here is not a new token.
- Accept: valid_o && ready_i with no capture gives valid_o<=0. data_o keeps its last value.
- Latency:
  - Last rail settling to valid_o high: SYNC_STAGES+2 clk edges, +1 for sampling uncertainty.
  - valid_o and ack_o change on the same edge.
- Backpressure: while valid_o=1 and ready_i=0, no capture and no ack. Upstream therefore stalls holding its token.
- Wrap-around: the TP ack phase and prev roll over indefinitely, with no counter limit.
- The block never presents the same token twice. The token count equals the ack transition count (TP) or the ack rising-edge count (FP).

Test Plan:
- Reset and idle, ENC="TP", WIDTH=33: hold rst 100 ns, rails static -> ack_o=0, valid_o=0, err_o=0 throughout.
- int_adder tokens in order: a=-10, b=20, cin=1; a=12, b=15, cin=1; a=-1, b=-1, cin=1; ready_i=1 -> data_o = 0x1_0000000B, 0x0_0000001C, 0x1_FFFFFFFF, in order. ack_o toggles exactly 3 times.
- Backpressure: ready_i=0, send 2 tokens -> first token held on valid_o, ack_o toggles once only. Raise ready_i -> second token appears; total 2 ack toggles.
- FP mode, WIDTH=8: drive 0xA5 then spacer -> valid_o with data_o=0xA5, ack_o high. ack_o falls exactly 2 cycles after syn is all-zero.
- Rail conflict, FP: force bit 3 both rails high -> err_o=1 sticky, no capture, ack_o unchanged until rst.
- Reset mid-token: assert rst after half the bits are valid -> all outputs 0 immediately (asynchronous reset, no clk edge needed). A clean token after reset is captured correctly.
